// File: rtl/scr1_tapc_pkg.sv
// Shared TAP controller definitions: DMI op/status encodings, chain ids, sequencer FSM states
// and DTMCS field positions.
package scr1_tapc_pkg;

  localparam logic [1:0] SCR1_DMI_OP_NOP = 2'd0;
  localparam logic [1:0] SCR1_DMI_OP_RD  = 2'd1;
  localparam logic [1:0] SCR1_DMI_OP_WR  = 2'd2;
  localparam logic [1:0] SCR1_DMI_OP_RSV = 2'd3;

  localparam logic [1:0] SCR1_DMI_STAT_SUCCESS = 2'd0;
  localparam logic [1:0] SCR1_DMI_STAT_FAILED  = 2'd2;
  localparam logic [1:0] SCR1_DMI_STAT_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    SCR1_CH_DTMCS      = 2'd0,
    SCR1_CH_DMI_ACCESS = 2'd1
  } type_scr1_ch_id_e;

  typedef enum logic {
    SCR1_DMI_FSM_IDLE = 1'b0,
    SCR1_DMI_FSM_REQ  = 1'b1
  } type_scr1_dmi_ctrl_fsm_e;

  localparam int unsigned SCR1_DTMCS_DMIRESET_BIT     = 16;
  localparam int unsigned SCR1_DTMCS_DMIHARDRESET_BIT = 17;
  localparam int unsigned SCR1_DTMCS_VERSION          = 1;

  // Busy takes precedence over a recorded failure.
  function automatic logic [1:0] scr1_dmi_status(input logic busy, input logic err);
    if (busy) begin
      return SCR1_DMI_STAT_BUSY;
    end else if (err) begin
      return SCR1_DMI_STAT_FAILED;
    end
    return SCR1_DMI_STAT_SUCCESS;
  endfunction

endpackage

// File: rtl/scr1_dmi_timeout_cnt.sv
// Saturating DMI response timeout counter; expired fires in the enabled cycle that would make
// the count reach TIMEOUT. TIMEOUT=0 never expires.
module scr1_dmi_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic trst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CntMax  = '1;
  localparam logic [CW-1:0] LastVal = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && enable && !clear && (cnt_q == LastVal);

endmodule

// File: rtl/scr1_dmi_chain_ctrl.sv
// SysCLK-domain DTMCS/DMI scan-chain sequencer: turns synchronized TAP strobes into single DMI
// transactions towards the Debug Module and keeps sticky busy/error status.
module scr1_dmi_chain_ctrl
  import scr1_tapc_pkg::*;
#(
  parameter int unsigned DMI_ABITS   = 7,
  parameter int unsigned DMI_TIMEOUT = 255,
  parameter int unsigned DTM_IDLE    = 1
) (
  input  logic                 clk,
  input  logic                 trst_n,
  input  logic                 ch_sel,
  input  logic [1:0]           ch_id,
  input  logic                 ch_capture,
  input  logic                 ch_shift,
  input  logic                 ch_update,
  input  logic                 ch_tdi,
  output logic                 ch_tdo,
  output logic                 dmi_req,
  output logic                 dmi_wr,
  output logic [DMI_ABITS-1:0] dmi_addr,
  output logic [31:0]          dmi_wdata,
  input  logic                 dmi_resp,
  input  logic [31:0]          dmi_rdata
);

  localparam int unsigned W = DMI_ABITS + 34;

  type_scr1_dmi_ctrl_fsm_e fsm_q, fsm_d;

  logic [W-1:0]         shreg_q, shreg_d;
  logic                 sticky_busy_q, sticky_busy_d;
  logic                 sticky_err_q, sticky_err_d;
  logic                 dmi_wr_q, dmi_wr_d;
  logic [DMI_ABITS-1:0] dmi_addr_q, dmi_addr_d;
  logic [31:0]          dmi_wdata_q, dmi_wdata_d;
  logic [DMI_ABITS-1:0] last_addr_q, last_addr_d;
  logic [31:0]          last_rdata_q, last_rdata_d;

  logic                 cap, sft, upd, is_dtmcs, is_dmi;
  logic                 upd_dtmcs, upd_dmi, abort, dmi_reset;
  logic                 in_idle, in_req, op_valid, req_start, resp_take, timeout_hit;
  logic                 cnt_expired;
  logic [1:0]           upd_op;
  logic [31:0]          upd_data;
  logic [DMI_ABITS-1:0] upd_addr;

  assign cap      = ch_sel & ch_capture;
  assign sft      = ch_sel & ch_shift;
  assign upd      = ch_sel & ch_update;
  assign is_dtmcs = (ch_id == SCR1_CH_DTMCS);
  assign is_dmi   = (ch_id == SCR1_CH_DMI_ACCESS);

  assign upd_dtmcs = upd & is_dtmcs;
  assign upd_dmi   = upd & is_dmi;
  assign abort     = upd_dtmcs & shreg_q[SCR1_DTMCS_DMIHARDRESET_BIT];
  assign dmi_reset = upd_dtmcs & (shreg_q[SCR1_DTMCS_DMIRESET_BIT] |
                                  shreg_q[SCR1_DTMCS_DMIHARDRESET_BIT]);

  assign upd_op   = shreg_q[1:0];
  assign upd_data = shreg_q[33:2];
  assign upd_addr = shreg_q[W-1:34];

  always_comb begin
    op_valid = 1'b0;
    case (upd_op)
      SCR1_DMI_OP_RD, SCR1_DMI_OP_WR:   op_valid = 1'b1;
      SCR1_DMI_OP_NOP, SCR1_DMI_OP_RSV: op_valid = 1'b0;
      default:                          op_valid = 1'b0;
    endcase
  end

  assign in_idle     = (fsm_q == SCR1_DMI_FSM_IDLE);
  assign req_start   = upd_dmi & ~sticky_busy_q & ~sticky_err_q & in_idle & op_valid;
  // An abort in the same cycle pre-empts both completion and timeout.
  assign in_req      = (fsm_q == SCR1_DMI_FSM_REQ) & ~abort;
  assign resp_take   = in_req & dmi_resp;
  assign timeout_hit = in_req & ~dmi_resp & cnt_expired;

  scr1_dmi_timeout_cnt #(
    .TIMEOUT(DMI_TIMEOUT)
  ) i_timeout_cnt (
    .clk    (clk),
    .trst_n (trst_n),
    .clear  (req_start | abort),
    .enable (fsm_q == SCR1_DMI_FSM_REQ),
    .expired(cnt_expired)
  );

  // FSM state register
  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) begin
      fsm_q <= SCR1_DMI_FSM_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next state
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      SCR1_DMI_FSM_IDLE: if (req_start) fsm_d = SCR1_DMI_FSM_REQ;
      SCR1_DMI_FSM_REQ:  if (abort || dmi_resp || cnt_expired) fsm_d = SCR1_DMI_FSM_IDLE;
      default:           fsm_d = SCR1_DMI_FSM_IDLE;
    endcase
  end

  // Datapath and sticky status next state
  always_comb begin
    shreg_d       = shreg_q;
    sticky_busy_d = sticky_busy_q;
    sticky_err_d  = sticky_err_q;
    dmi_wr_d      = dmi_wr_q;
    dmi_addr_d    = dmi_addr_q;
    dmi_wdata_d   = dmi_wdata_q;
    last_addr_d   = last_addr_q;
    last_rdata_d  = last_rdata_q;

    if (cap) begin
      if (is_dtmcs) begin
        shreg_d[31:0] = {14'd0, 2'b00, 1'b0, 3'(DTM_IDLE),
                         scr1_dmi_status(sticky_busy_q, sticky_err_q),
                         6'(DMI_ABITS), 4'(SCR1_DTMCS_VERSION)};
      end else if (is_dmi) begin
        shreg_d = {last_addr_q, last_rdata_q,
                   scr1_dmi_status(~in_idle | sticky_busy_q, sticky_err_q)};
        if (!in_idle) sticky_busy_d = 1'b1;
      end else begin
        shreg_d = '0;
      end
    end else if (sft) begin
      shreg_d = {ch_tdi, shreg_q[W-1:1]};
    end

    if (dmi_reset) begin
      sticky_busy_d = 1'b0;
      sticky_err_d  = 1'b0;
    end

    if (upd_dmi && !sticky_busy_q && !sticky_err_q && !in_idle) sticky_busy_d = 1'b1;

    if (req_start) begin
      dmi_wr_d    = (upd_op == SCR1_DMI_OP_WR);
      dmi_addr_d  = upd_addr;
      dmi_wdata_d = upd_data;
      last_addr_d = upd_addr;
    end

    if (resp_take && !dmi_wr_q) last_rdata_d = dmi_rdata;
    if (timeout_hit) sticky_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) begin
      shreg_q       <= '0;
      sticky_busy_q <= 1'b0;
      sticky_err_q  <= 1'b0;
      dmi_wr_q      <= 1'b0;
      dmi_addr_q    <= '0;
      dmi_wdata_q   <= '0;
      last_addr_q   <= '0;
      last_rdata_q  <= '0;
    end else begin
      shreg_q       <= shreg_d;
      sticky_busy_q <= sticky_busy_d;
      sticky_err_q  <= sticky_err_d;
      dmi_wr_q      <= dmi_wr_d;
      dmi_addr_q    <= dmi_addr_d;
      dmi_wdata_q   <= dmi_wdata_d;
      last_addr_q   <= last_addr_d;
      last_rdata_q  <= last_rdata_d;
    end
  end

  // Outputs
  always_comb begin
    dmi_req   = (fsm_q == SCR1_DMI_FSM_REQ);
    dmi_wr    = dmi_wr_q;
    dmi_addr  = dmi_addr_q;
    dmi_wdata = dmi_wdata_q;
    ch_tdo    = shreg_q[0];
  end

endmodule

// File: tb/tb_scr1_dmi_chain_ctrl.sv
// Directed bench for scr1_dmi_chain_ctrl with ABITS=7 (41-bit DMI chain) and a 4-cycle timeout.
module tb_scr1_dmi_chain_ctrl;

  logic        clk = 1'b0;
  logic        trst_n;
  logic        ch_sel, ch_capture, ch_shift, ch_update, ch_tdi, ch_tdo;
  logic [1:0]  ch_id;
  logic        dmi_req, dmi_wr, dmi_resp;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata, dmi_rdata;

  int checks   = 0;
  int failures = 0;

  scr1_dmi_chain_ctrl #(
    .DMI_ABITS  (7),
    .DMI_TIMEOUT(4),
    .DTM_IDLE   (1)
  ) dut (
    .clk       (clk),
    .trst_n    (trst_n),
    .ch_sel    (ch_sel),
    .ch_id     (ch_id),
    .ch_capture(ch_capture),
    .ch_shift  (ch_shift),
    .ch_update (ch_update),
    .ch_tdi    (ch_tdi),
    .ch_tdo    (ch_tdo),
    .dmi_req   (dmi_req),
    .dmi_wr    (dmi_wr),
    .dmi_addr  (dmi_addr),
    .dmi_wdata (dmi_wdata),
    .dmi_resp  (dmi_resp),
    .dmi_rdata (dmi_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          resp_cyc;
    int          exp_req;
    bit          exp_err;
    logic [40:0] exp_cap;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_capture(input logic [1:0] id);
    ch_sel = 1'b1; ch_id = id; ch_capture = 1'b1;
    tick();
    ch_capture = 1'b0;
  endtask

  task automatic pulse_update(input logic [1:0] id);
    ch_sel = 1'b1; ch_id = id; ch_update = 1'b1;
    tick();
    ch_update = 1'b0;
  endtask

  task automatic shift_bits(input logic [40:0] din, input int n, output logic [40:0] dout);
    dout = '0;
    ch_sel = 1'b1;
    for (int i = 0; i < n; i++) begin
      dout[i]  = ch_tdo;
      ch_tdi   = din[i];
      ch_shift = 1'b1;
      tick();
      ch_shift = 1'b0;
    end
  endtask

  task automatic dmi_scan(input logic [40:0] din);
    logic [40:0] d;
    pulse_capture(2'd1);
    shift_bits(din, 41, d);
    pulse_update(2'd1);
  endtask

  task automatic dmi_read_chain(output logic [40:0] d);
    pulse_capture(2'd1);
    shift_bits('0, 41, d);
  endtask

  task automatic dtmcs_read(output logic [31:0] v);
    logic [40:0] d;
    pulse_capture(2'd0);
    shift_bits('0, 32, d);
    v = d[31:0];
  endtask

  task automatic dtmcs_write(input logic [31:0] v);
    logic [40:0] d;
    pulse_capture(2'd0);
    shift_bits({9'd0, v}, 41, d);
    pulse_update(2'd0);
  endtask

  initial begin
    logic [40:0] chain;
    logic [31:0] dtmcs;
    int          cnt;

    // op, addr, wdata, rdata driven with resp, resp cycle (0=none), req cycles, err, capture
    tbl[0] = '{2'd2, 7'h10, 32'hDEADBEEF, 32'h11111111, 3, 3, 1'b0, {7'h10, 32'h00000000, 2'd0}};
    tbl[1] = '{2'd1, 7'h11, 32'h00000000, 32'h12345678, 1, 1, 1'b0, {7'h11, 32'h12345678, 2'd0}};
    tbl[2] = '{2'd1, 7'h22, 32'h00000000, 32'hA5A50F0F, 4, 4, 1'b0, {7'h22, 32'hA5A50F0F, 2'd0}};
    tbl[3] = '{2'd0, 7'h33, 32'hFFFF0000, 32'h0, 0, 0, 1'b0, {7'h22, 32'hA5A50F0F, 2'd0}};
    tbl[4] = '{2'd1, 7'h44, 32'h00000000, 32'h0, 0, 4, 1'b1, {7'h44, 32'hA5A50F0F, 2'd2}};
    tbl[5] = '{2'd3, 7'h55, 32'h12121212, 32'h0, 0, 0, 1'b0, {7'h44, 32'hA5A50F0F, 2'd0}};
    tbl[6] = '{2'd2, 7'h7F, 32'h00000001, 32'h66666666, 2, 2, 1'b0, {7'h7F, 32'hA5A50F0F, 2'd0}};

    trst_n = 1'b0; ch_sel = 1'b0; ch_id = 2'd0; ch_capture = 1'b0; ch_shift = 1'b0;
    ch_update = 1'b0; ch_tdi = 1'b0; dmi_resp = 1'b0; dmi_rdata = '0;
    tick(); tick();
    check("rst_dmi_req", dmi_req, 0);
    check("rst_dmi_wr", dmi_wr, 0);
    check("rst_dmi_addr", dmi_addr, 0);
    check("rst_dmi_wdata", dmi_wdata, 0);
    check("rst_ch_tdo", ch_tdo, 0);
    trst_n = 1'b1;
    tick();

    dtmcs_read(dtmcs);
    check("dtmcs_idle_value", dtmcs, 32'h00001071);

    foreach (tbl[n]) begin
      dmi_scan({tbl[n].addr, tbl[n].wdata, tbl[n].op});
      if (tbl[n].op == 2'd1 || tbl[n].op == 2'd2) begin
        check($sformatf("v%0d_req_rise", n), dmi_req, 1);
        check($sformatf("v%0d_wr", n), dmi_wr, (tbl[n].op == 2'd2));
        check($sformatf("v%0d_addr", n), dmi_addr, tbl[n].addr);
        if (tbl[n].op == 2'd2) check($sformatf("v%0d_wdata", n), dmi_wdata, tbl[n].wdata);
      end else begin
        check($sformatf("v%0d_no_req", n), dmi_req, 0);
      end
      cnt = 0;
      for (int k = 1; k <= 10; k++) begin
        if (!dmi_req) break;
        if (k == tbl[n].resp_cyc) begin
          dmi_resp  = 1'b1;
          dmi_rdata = tbl[n].rdata;
        end
        tick();
        dmi_resp = 1'b0;
        cnt++;
      end
      check($sformatf("v%0d_req_cycles", n), cnt, tbl[n].exp_req);
      dmi_read_chain(chain);
      check($sformatf("v%0d_capture", n), chain, tbl[n].exp_cap);
      if (tbl[n].exp_err) begin
        dtmcs_read(dtmcs);
        check($sformatf("v%0d_dtmcs_failed", n), dtmcs, 32'h00001871);
        dmi_scan({7'h0A, 32'h0, 2'd2});
        check($sformatf("v%0d_upd_ignored", n), dmi_req, 0);
        dtmcs_write(32'h00010000);
      end
    end

    // Second update and a capture while a read is outstanding
    dmi_scan({7'h05, 32'h0, 2'd1});
    check("busy_req_rise", dmi_req, 1);
    pulse_update(2'd1);
    check("busy_req_held", dmi_req, 1);
    check("busy_addr_held", dmi_addr, 7'h05);
    pulse_capture(2'd1);
    check("busy_capture_tdo", ch_tdo, 1);
    dmi_resp = 1'b1; dmi_rdata = 32'h0BADF00D;
    tick();
    dmi_resp = 1'b0;
    check("busy_req_drop", dmi_req, 0);
    dmi_read_chain(chain);
    check("busy_capture_op3", chain, {7'h05, 32'h0BADF00D, 2'd3});
    dtmcs_read(dtmcs);
    check("busy_dtmcs", dtmcs, 32'h00001C71);
    dmi_scan({7'h0A, 32'h1, 2'd2});
    check("busy_upd_ignored", dmi_req, 0);
    dtmcs_write(32'h00010000);
    dmi_read_chain(chain);
    check("busy_cleared", chain, {7'h05, 32'h0BADF00D, 2'd0});

    // dmihardreset (bit 17 = data bit 15 still in the chain) aborts the read
    dmi_scan({7'h06, 32'h00008000, 2'd1});
    check("abort_req_rise", dmi_req, 1);
    pulse_update(2'd0);
    check("abort_req_drop", dmi_req, 0);
    dmi_resp = 1'b1; dmi_rdata = 32'hBAD0BAD0;
    tick();
    dmi_resp = 1'b0;
    dmi_read_chain(chain);
    check("abort_late_resp", chain, {7'h06, 32'h0BADF00D, 2'd0});

    // Asynchronous reset mid-request
    dmi_scan({7'h09, 32'hCAFEF00D, 2'd2});
    check("trst_req_rise", dmi_req, 1);
    trst_n = 1'b0;
    #2;
    check("trst_req_async", dmi_req, 0);
    check("trst_wr", dmi_wr, 0);
    check("trst_addr", dmi_addr, 0);
    check("trst_wdata", dmi_wdata, 0);
    tick();
    trst_n = 1'b1;
    tick();
    dmi_read_chain(chain);
    check("trst_capture", chain, 41'h0);

    // Strobes ignored without ch_sel
    shift_bits({7'h0C, 32'h0, 2'd1}, 41, chain);
    ch_sel = 1'b0; ch_id = 2'd1; ch_update = 1'b1;
    tick();
    ch_update = 1'b0;
    check("nosel_no_req", dmi_req, 0);
    pulse_update(2'd1);
    check("sel_req", dmi_req, 1);
    check("sel_addr", dmi_addr, 7'h0C);
    dmi_resp = 1'b1; dmi_rdata = 32'h13579BDF;
    tick();
    dmi_resp = 1'b0;
    check("sel_req_drop", dmi_req, 0);
    dmi_read_chain(chain);
    check("sel_capture", chain, {7'h0C, 32'h13579BDF, 2'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
